// File: rtl/cnt32_ev_pkg.sv
// Shared types and constants for the cnt32 event FIFO.
// Defines the entry record, the event-kind encodings and the parameter defaults.
package cnt32_ev_pkg;

  localparam int unsigned EV_DEPTH_DEF = 8;
  localparam int unsigned EV_TOT_W_DEF = 16;

  localparam logic [1:0] KIND_RCO  = 2'b01;
  localparam logic [1:0] KIND_LOAD = 2'b10;
  localparam logic [1:0] KIND_BOTH = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  kind;
    logic [15:0] stamp;
  } ev_entry_t;

  // Event kind from the two counter pulses; 0 means no event.
  function automatic logic [1:0] ev_kind_f(input logic rco, input logic load);
    logic [1:0] k;
    k = '0;
    if (rco && load) k = KIND_BOTH;
    else if (load)   k = KIND_LOAD;
    else if (rco)    k = KIND_RCO;
    return k;
  endfunction

endpackage

// File: rtl/ev_fifo_mem.sv
// Show-ahead FIFO storage with read/write pointers and occupancy count.
// A push while full is accepted only when a pop happens at the same edge;
// a pop while empty is ignored. Storage itself is not reset.
module ev_fifo_mem
  import cnt32_ev_pkg::*;
#(
  parameter int unsigned DEPTH = EV_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  ev_entry_t                wr_entry_i,
  output ev_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ev_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head entry presented combinationally; forced to zero while empty so
  // unreset storage never reaches the outputs.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers (wrap modulo DEPTH) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write; contents intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry_i;
  end

endmodule

// File: rtl/cnt32_event_fifo.sv
// Event capture FIFO for a 32-bit counter stage: records Q_ on qualified
// rco_/load_ pulses, tracks a sticky drop flag and a saturating rco total.
// Optional feature macro: EVFIFO_TIMESTAMP_EN (16-bit cycle stamp per entry).
module cnt32_event_fifo
  import cnt32_ev_pkg::*;
#(
  parameter int unsigned DEPTH = EV_DEPTH_DEF,
  parameter int unsigned TOT_W = EV_TOT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_,
  input  logic [31:0]            Q_,
  input  logic                   rco_,
  input  logic                   load_,
  input  logic                   pop,
  input  logic                   clr_ovf,
  output logic                   ev_valid,
  output logic [31:0]            ev_data,
  output logic [1:0]             ev_kind,
  output logic [15:0]            ev_stamp,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [TOT_W-1:0]       rco_total
);

  logic             qual;
  logic             drop;
  ev_entry_t        wr_entry;
  ev_entry_t        head;
  logic             ovf_q, ovf_d;
  logic [TOT_W-1:0] tot_q, tot_d;

  assign qual = enable_ && (rco_ || load_);
  // When full, a pop at the same edge frees the slot, so only an unpopped
  // push is lost.
  assign drop = qual && full && !pop;

  assign wr_entry.data = Q_;
  assign wr_entry.kind = ev_kind_f(rco_, load_);

`ifdef EVFIFO_TIMESTAMP_EN
  logic [15:0] ts_q;

  // Free-running cycle counter captured with each pushed entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 16'd1;
  end

  assign wr_entry.stamp = ts_q;
`else
  // Stamp field is written as constant zero, so the stored bits fold away.
  assign wr_entry.stamp = '0;
`endif

  ev_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (qual),
    .pop_i      (pop),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (fifo_count),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign ev_valid  = !empty;
  assign ev_data   = head.data;
  assign ev_kind   = head.kind;
  assign ev_stamp  = head.stamp;
  assign overflow  = ovf_q;
  assign rco_total = tot_q;

  // Sticky overflow (set beats clear) and saturating rco total next-state.
  always_comb begin
    ovf_d = ovf_q;
    tot_d = tot_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    if (qual && rco_ && (tot_q != '1)) tot_d = tot_q + TOT_W'(1);
  end

  // Overflow flag and rco total registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      tot_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      tot_q <= tot_d;
    end
  end

endmodule

// File: tb/tb_cnt32_event_fifo.sv
// Scoreboard bench for cnt32_event_fifo: stimulus updates a queue-level
// reference model at each clock edge; an independent monitor compares the
// DUT head and status against it. Honors EVFIFO_TIMESTAMP_EN for stamps.
module tb_cnt32_event_fifo;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TOT_W   = 4;
  localparam int unsigned TOT_MAX = (1 << TOT_W) - 1;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  k;
    logic [15:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_ = 1'b0;
  logic [31:0] Q_ = '0;
  logic        rco_ = 1'b0;
  logic        load_ = 1'b0;
  logic        pop = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        ev_valid;
  logic [31:0] ev_data;
  logic [1:0]  ev_kind;
  logic [15:0] ev_stamp;
  logic [3:0]  fifo_count;
  logic        full, empty, overflow;
  logic [TOT_W-1:0] rco_total;

  cnt32_event_fifo #(
    .DEPTH (DEPTH),
    .TOT_W (TOT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_    (enable_),
    .Q_         (Q_),
    .rco_       (rco_),
    .load_      (load_),
    .pop        (pop),
    .clr_ovf    (clr_ovf),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_kind    (ev_kind),
    .ev_stamp   (ev_stamp),
    .fifo_count (fifo_count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .rco_total  (rco_total)
  );

  always #5 clk = ~clk;

  // Reference model state
  exp_t        exp_q[$];
  int unsigned mdl_cnt = 0;
  bit          mdl_ovf = 0;
  int unsigned mdl_tot = 0;
  int unsigned ts_m    = 0;
  bit          mon_en  = 0;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update for the edge that just consumed the current inputs.
  task automatic model_edge();
    bit   qual, popped, drop;
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      mdl_cnt = 0;
      mdl_ovf = 0;
      mdl_tot = 0;
      ts_m    = 0;
    end else begin
      qual   = enable_ && (rco_ || load_);
      popped = pop && (mdl_cnt > 0);
      drop   = qual && (mdl_cnt == DEPTH) && !popped;
      if (qual && !drop) begin
        e.d = Q_;
        e.k = {load_, rco_};
`ifdef EVFIFO_TIMESTAMP_EN
        e.s = 16'(ts_m);
`else
        e.s = 16'd0;
`endif
        exp_q.push_back(e);
        mdl_cnt++;
      end
      if (popped) mdl_cnt--;
      if (drop) mdl_ovf = 1;
      else if (clr_ovf) mdl_ovf = 0;
      if (qual && rco_ && mdl_tot != TOT_MAX) mdl_tot++;
      ts_m = (ts_m + 1) % 65536;
    end
  endtask

  task automatic drive(input logic en, input logic r, input logic l,
                       input logic [31:0] q, input logic p, input logic c);
    @(negedge clk); #1;
    enable_ = en; rco_ = r; load_ = l; Q_ = q; pop = p; clr_ovf = c;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 2 * DEPTH && mdl_cnt > 0; i++)
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: samples mid-cycle, compares status and head, consumes the
  // expected entry when the DUT hands one over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (mon_en) begin
        chk("ev_valid",   64'(ev_valid),   64'(mdl_cnt != 0));
        chk("fifo_count", 64'(fifo_count), 64'(mdl_cnt));
        chk("full",       64'(full),       64'(mdl_cnt == DEPTH));
        chk("empty",      64'(empty),      64'(mdl_cnt == 0));
        chk("overflow",   64'(overflow),   64'(mdl_ovf));
        chk("rco_total",  64'(rco_total),  64'(mdl_tot));
        if (!ev_valid) begin
          chk("empty_head", 64'({ev_data, ev_kind, ev_stamp}), 64'd0);
        end else if (exp_q.size() == 0) begin
          chk("head_unexpected", 64'(ev_data), 64'd0);
          chk("head_unexpected_valid", 64'(ev_valid), 64'd0);
        end else begin
          e = exp_q[0];
          chk("ev_data",  64'(ev_data),  64'(e.d));
          chk("ev_kind",  64'(ev_kind),  64'(e.k));
          chk("ev_stamp", 64'(ev_stamp), 64'(e.s));
          if (pop) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    idle(3);
    #2;
    // Reset values
    chk("rst_valid", 64'(ev_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_total", 64'(rco_total), 64'd0);
    chk("rst_head", 64'({ev_data, ev_kind, ev_stamp}), 64'd0);
    @(negedge clk); #1;
    reset  = 1'b1;
    mon_en = 1;

    // Edges 0..2 idle, rco with Q_=0 at edge 3, load at edge 10.
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    idle(6);
    drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    idle(1);
    drain();

    // Simultaneous rco and load
    drive(1'b1, 1'b1, 1'b1, 32'hA5A5_0003, 1'b0, 1'b0);
    idle(1);
    drain();

    // Nine events into eight slots, then drain and clear overflow
    for (int unsigned i = 0; i < 9; i++)
      drive(1'b1, 1'b1, 1'b0, 32'h1111_1111 * (i + 1), 1'b0, 1'b0);
    drain();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Full with simultaneous push and pop, then push while empty with pop
    for (int unsigned i = 0; i < DEPTH; i++)
      drive(1'b1, 1'b0, 1'b1, 32'hC000_0000 + i, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drain();
    drive(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0);
    drain();

    // Disabled pulses are ignored
    for (int unsigned i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_0000 + i, 1'b0, 1'b0);

    // Randomized traffic, including drop/clear collisions and saturation
    for (int unsigned i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 9) < 3), $urandom,
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
    drain();

    // Asynchronous reset with five entries stored
    for (int unsigned i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 1'b0, 32'h5000_0000 + i, 1'b0, 1'b0);
    @(negedge clk); #1;
    mon_en = 0;
    reset  = 1'b0;
    #1;
    chk("async_empty", 64'(empty), 64'd1);
    chk("async_count", 64'(fifo_count), 64'd0);
    chk("async_valid", 64'(ev_valid), 64'd0);
    chk("async_head", 64'({ev_data, ev_kind, ev_stamp}), 64'd0);
    chk("async_total", 64'(rco_total), 64'd0);
    @(posedge clk);
    model_edge();
    idle(1);
    @(negedge clk); #1;
    reset  = 1'b1;
    mon_en = 1;
    drive(1'b1, 1'b0, 1'b1, 32'h7777_0001, 1'b0, 1'b0);
    idle(2);
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
